// File: rtl/fpall_req_sched_pkg.sv
// Shared types for the FPALL request scheduler: FPU format/opcode encodings,
// scheduler FSM states and the packed request bundle driven onto the FPU bus.
package fpall_req_sched_pkg;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    BF16 = 2'd2,
    FP64 = 2'd3
  } fp_fmt_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_MIN = 3'd3,
    OP_MAX = 3'd4,
    OP_CMP = 3'd5,
    OP_CVT = 3'd6,
    OP_NOP = 3'd7
  } fp_op_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAINING = 2'd1,
    DRAINED  = 2'd2
  } sched_state_e;

  typedef struct packed {
    fp_fmt_e     fmt;
    fp_op_e      op;
    logic [31:0] x;
    logic [31:0] y;
  } fpreq_t;

  localparam fpreq_t FPREQ_RST = '{fmt: FP32, op: OP_ADD, x: '0, y: '0};

endpackage

// File: rtl/fpall_rr_arb.sv
// Combinational round-robin arbiter: searches req_i starting at ptr_i and
// returns a one-hot grant plus the winning index.
module fpall_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW:0]   cand_w;
  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand_w    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // Rotate the search origin to ptr_i, wrapping modulo NREQ.
      cand_w = {1'b0, ptr_i} + (IDW+1)'(k);
      if (cand_w >= NREQ_W) cand_w = cand_w - NREQ_W;
      cand = cand_w[IDW-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fpall_req_sched.sv
// Round-robin scheduler sharing one fixed-latency FPU among NREQ requesters,
// with in-flight tag tracking and a drain handshake. Optional perf counters
// are enabled by defining FPSCHED_PERF_CNT_EN.
module fpall_req_sched
  import fpall_req_sched_pkg::*;
#(
  parameter int  NREQ = 4,
  parameter int  LAT  = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  fp_fmt_e         req_fmt [NREQ],
  input  fp_op_e          req_op  [NREQ],
  input  logic [31:0]     req_x   [NREQ],
  input  logic [31:0]     req_y   [NREQ],
  output fp_fmt_e         fpu_fmt,
  output fp_op_e          fpu_op,
  output logic [31:0]     fpu_x,
  output logic [31:0]     fpu_y,
  input  logic [31:0]     fpu_r,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [31:0]     rsp_data,
  input  logic            drain_req,
  output logic            drained
`ifdef FPSCHED_PERF_CNT_EN
  ,
  output logic [31:0]     perf_issue_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } tag_t;

  localparam logic [IDW-1:0] PTR_LAST = IDW'(NREQ - 1);

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  fpreq_t         fpu_q, fpu_d;
  tag_t [LAT:0]   tag_q;
  tag_t           tag_in;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            accept_en;
  logic            accept;
  logic            pipe_busy;

  fpall_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // drain_req gates acceptance combinationally so a request arriving with
  // the drain rise is never taken.
  assign accept_en = (state_q == RUN) && !drain_req;
  assign req_ready = accept_en ? gnt : '0;
  assign accept    = accept_en && (|gnt);

  always_comb begin
    ptr_d  = ptr_q;
    fpu_d  = fpu_q;
    tag_in = '0;
    if (accept) begin
      ptr_d  = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + IDW'(1);
      fpu_d  = '{fmt: req_fmt[gnt_idx], op: req_op[gnt_idx],
                 x: req_x[gnt_idx], y: req_y[gnt_idx]};
      tag_in = '{v: 1'b1, id: gnt_idx};
    end
  end

  // Only stages that survive the next edge count, so DRAINED is entered on
  // the same edge that retires the last response.
  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) pipe_busy = pipe_busy | tag_q[i].v;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (drain_req) state_d = DRAINING;
      DRAINING: begin
        if (!drain_req)     state_d = RUN;
        else if (!pipe_busy) state_d = DRAINED;
      end
      DRAINED:  if (!drain_req) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ptr_q   <= '0;
      fpu_q   <= FPREQ_RST;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fpu_q   <= fpu_d;
      tag_q   <= {tag_q[LAT-1:0], tag_in};
    end
  end

  assign fpu_fmt   = fpu_q.fmt;
  assign fpu_op    = fpu_q.op;
  assign fpu_x     = fpu_q.x;
  assign fpu_y     = fpu_q.y;
  assign rsp_valid = tag_q[LAT].v;
  assign rsp_id    = tag_q[LAT].id;
  assign rsp_data  = rsp_valid ? fpu_r : '0;
  assign drained   = (state_q == DRAINED) && !pipe_busy && !rsp_valid;

`ifdef FPSCHED_PERF_CNT_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = (|req_valid) && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && (issue_cnt_q != '1)) issue_cnt_q <= issue_cnt_q + 32'd1;
      if (stall && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_issue_cnt = issue_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fpall_req_sched.sv
// Scoreboard bench for fpall_req_sched: directed requests with hand-computed
// FP32 sums, a fixed-latency FPU stub, and a monitor that checks grants/responses.
`timescale 1ns/1ps
module tb_fpall_req_sched;
  import fpall_req_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int NV   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0] req_valid, req_ready;
  fp_fmt_e         req_fmt [NREQ];
  fp_op_e          req_op  [NREQ];
  logic [31:0]     req_x   [NREQ];
  logic [31:0]     req_y   [NREQ];
  fp_fmt_e         fpu_fmt;
  fp_op_e          fpu_op;
  logic [31:0]     fpu_x, fpu_y, fpu_r, rsp_data;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic            drain_req, drained;
`ifdef FPSCHED_PERF_CNT_EN
  logic [31:0]     perf_issue_cnt, perf_stall_cnt;
`endif

  fpall_req_sched #(
    .NREQ (NREQ),
    .LAT  (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_fmt   (req_fmt),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .fpu_fmt   (fpu_fmt),
    .fpu_op    (fpu_op),
    .fpu_x     (fpu_x),
    .fpu_y     (fpu_y),
    .fpu_r     (fpu_r),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .drain_req (drain_req),
    .drained   (drained)
`ifdef FPSCHED_PERF_CNT_EN
    ,
    .perf_issue_cnt (perf_issue_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Hand-computed FP32 sums: 1+2, 2+2, 3+1, 4+4, 1+1, 5+3, 8+8, 0.5+0.5
  logic [31:0] vx [NV] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                           32'h3F800000, 32'h40A00000, 32'h41000000, 32'h3F000000};
  logic [31:0] vy [NV] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h40800000,
                           32'h3F800000, 32'h40400000, 32'h41000000, 32'h3F000000};
  logic [31:0] vs [NV] = '{32'h40400000, 32'h40800000, 32'h40800000, 32'h41000000,
                           32'h40000000, 32'h41000000, 32'h41800000, 32'h3F800000};

  // FPU stub: samples its inputs each edge, result appears LAT edges after issue.
  function automatic logic [31:0] fpu_model(input logic [31:0] x, input logic [31:0] y);
    for (int i = 0; i < NV; i++) if (vx[i] == x && vy[i] == y) return vs[i];
    return 32'hDEADBEEF;
  endfunction

  logic [31:0] fp_pipe [LAT];
  always @(posedge clk) begin
    fp_pipe[0] <= fpu_model(fpu_x, fpu_y);
    for (int i = 1; i < LAT; i++) fp_pipe[i] <= fp_pipe[i-1];
  end
  assign fpu_r = fp_pipe[LAT-1];

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_rsp [$];
  int   exp_gnt [$];
  int   pend    [NREQ][$];
  logic [NREQ-1:0] hold_valid;
  logic drain_cmd;
  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every offered grant and every response is matched against the queues.
  always @(negedge clk) begin : monitor
    int   g;
    rsp_t r;
    #2;
    if (rst_n) begin
      if (|req_ready) begin
        tests++;
        if (exp_gnt.size() == 0) begin
          fails++;
          $display("FAIL unexpected_grant: got %b expected none", req_ready);
        end else begin
          g = exp_gnt.pop_front();
          if (req_ready !== NREQ'(1 << g)) begin
            fails++;
            $display("FAIL grant: got %b expected %b", req_ready, NREQ'(1 << g));
          end
        end
      end
      if (rsp_valid) begin
        tests++;
        if (exp_rsp.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rsp: got id %0d data %h expected none", rsp_id, rsp_data);
        end else begin
          r = exp_rsp.pop_front();
          if (rsp_id !== r.id || rsp_data !== r.data) begin
            fails++;
            $display("FAIL rsp: got id %0d data %h expected id %0d data %h",
                     rsp_id, rsp_data, r.id, r.data);
          end
        end
      end
    end
  end

  // One cycle: drive at negedge, record the accept that the next edge will take.
  task automatic tick();
    @(negedge clk);
    drain_req = drain_cmd;
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_x[i]     = vx[pend[i][0]];
        req_y[i]     = vy[pend[i][0]];
      end else begin
        req_valid[i] = hold_valid[i];
      end
    end
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i] && pend[i].size() > 0) begin
        exp_rsp.push_back('{id: 2'(i), data: vs[pend[i][0]]});
        void'(pend[i].pop_front());
      end
    end
  endtask

  function automatic logic busy();
    logic b = (exp_rsp.size() != 0) || (exp_gnt.size() != 0);
    for (int i = 0; i < NREQ; i++) if (pend[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy() && n < 40) begin
      tick();
      n++;
    end
    repeat (2) tick();
    check(name, 32'(busy()), 32'd0);
  endtask

  task automatic check_reset(input string name);
    check({name, "_ready"}, 32'(req_ready), 32'd0);
    check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({name, "_rsp_data"}, rsp_data, 32'd0);
    check({name, "_drained"}, 32'(drained), 32'd0);
    check({name, "_fpu_x"}, fpu_x, 32'd0);
    check({name, "_fpu_y"}, fpu_y, 32'd0);
    check({name, "_fpu_fmt"}, 32'(fpu_fmt), 32'(FP32));
    check({name, "_fpu_op"}, 32'(fpu_op), 32'(OP_ADD));
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    exp_rsp.delete();
    #1;
    check_reset(name);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n_rsp, last_rsp, first_drn, rdy_seen, n;
    req_valid  = '0;
    drain_req  = 1'b0;
    drain_cmd  = 1'b0;
    hold_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_fmt[i] = FP32;
      req_op[i]  = OP_ADD;
      req_x[i]   = '0;
      req_y[i]   = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // All four continuously valid from pointer 0: grants 0,1,2,3,0,1,2,3.
    for (int i = 0; i < NREQ; i++) begin
      pend[i].push_back(i);
      pend[i].push_back(i + 4);
    end
    for (int i = 0; i < 8; i++) exp_gnt.push_back(i % NREQ);
    for (int t = 1; t <= 12; t++) begin
      tick();
      check($sformatf("t2_rsp_cadence_%0d", t), 32'(rsp_valid), 32'((t >= 4) && (t <= 11)));
    end
    wait_idle("t2_idle");

    // Single requester 2: 1.0 + 2.0 returns 3.0 after edge k+LAT.
    pend[2].push_back(0);
    exp_gnt.push_back(2);
    tick();
    check("t1_ready", 32'(req_ready), 32'b0100);
    tick();
    check("t1_fpu_x", fpu_x, 32'h3F800000);
    check("t1_fpu_y", fpu_y, 32'h40000000);
    check("t1_fpu_fmt", 32'(fpu_fmt), 32'(FP32));
    check("t1_fpu_op", 32'(fpu_op), 32'(OP_ADD));
    check("t1_rsp_early1", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_rsp_early2", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_id", 32'(rsp_id), 32'd2);
    check("t1_rsp_data", rsp_data, 32'h40400000);
    tick();
    check("t1_rsp_after", 32'(rsp_valid), 32'd0);
    check("t1_rsp_masked", rsp_data, 32'd0);
    wait_idle("t1_idle");

    // Requester 1 back-to-back, requester 3 sporadic; pointer starts at 3.
    for (int i = 1; i <= 6; i++) pend[1].push_back(i);
    foreach (exp_gnt[i]) ;
    exp_gnt.push_back(1); exp_gnt.push_back(1); exp_gnt.push_back(3); exp_gnt.push_back(1);
    exp_gnt.push_back(1); exp_gnt.push_back(3); exp_gnt.push_back(1); exp_gnt.push_back(1);
    tick();
    tick();
    pend[3].push_back(7);
    tick();
    tick();
    tick();
    pend[3].push_back(0);
    tick();
    tick();
    tick();
    wait_idle("t3_idle");

    // Drain with two ops in flight; requester 2 arrives with the drain rise.
    pend[0].push_back(1);
    pend[1].push_back(2);
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    tick();
    tick();
    drain_cmd = 1'b1;
    pend[2].push_back(3);
    tick();
    check("t4_ready_drain", 32'(req_ready), 32'd0);
    check("t4_drained_early", 32'(drained), 32'd0);
    n_rsp = 0; last_rsp = -1; first_drn = -1; rdy_seen = 0; n = 0;
    while (first_drn < 0 && n < 12) begin
      n++;
      tick();
      if (rsp_valid) begin n_rsp++; last_rsp = n; end
      if (drained) first_drn = n;
      if (|req_ready) rdy_seen++;
    end
    check("t4_rsp_count", 32'(n_rsp), 32'd2);
    check("t4_drained_timing", 32'(first_drn), 32'(last_rsp + 1));
    check("t4_no_grant_draining", 32'(rdy_seen), 32'd0);
    drain_cmd = 1'b0;
    exp_gnt.push_back(2);
    tick();
    check("t4_ready_still_drained", 32'(req_ready), 32'd0);
    tick();
    check("t4_resume", 32'(req_ready), 32'b0100);
    wait_idle("t4_idle");

    // Reset with two ops in flight; pointer (currently 3) must restart at 0.
    pend[0].push_back(4);
    pend[1].push_back(5);
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    tick();
    tick();
    do_reset("t5");
    n_rsp = 0;
    repeat (6) begin
      tick();
      if (rsp_valid) n_rsp++;
    end
    check("t5_no_rsp_after_reset", 32'(n_rsp), 32'd0);
    for (int i = 0; i < NREQ; i++) begin
      pend[i].push_back(i + 4);
      exp_gnt.push_back(i);
    end
    tick();
    check("t5_ptr_restart", 32'(req_ready), 32'b0001);
    wait_idle("t5_idle");

`ifdef FPSCHED_PERF_CNT_EN
    // Ten accepts, then three cycles of a valid request blocked by drain.
    do_reset("t6");
    check("t6_issue_rst", perf_issue_cnt, 32'd0);
    check("t6_stall_rst", perf_stall_cnt, 32'd0);
    for (int i = 0; i < 10; i++) begin
      pend[0].push_back(i % NV);
      exp_gnt.push_back(0);
    end
    repeat (10) tick();
    repeat (4) tick();
    drain_cmd  = 1'b1;
    hold_valid = 4'b0001;
    repeat (3) tick();
    drain_cmd  = 1'b0;
    hold_valid = '0;
    repeat (3) tick();
    check("t6_issue_cnt", perf_issue_cnt, 32'd10);
    check("t6_stall_cnt", perf_stall_cnt, 32'd3);
    wait_idle("t6_idle");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpall_req_sched.md
Name: fpall_req_sched

Overview:
- Round-robin scheduler that shares one FPALL_Shared_combine unit between NREQ requesters (e.g. scalar lanes / LSU-side helpers).
- Accepts per-requester valid/ready requests {fmt, opcode, X, Y}, registers the winner onto the FPU input bus and tracks in-flight tags through the fixed-latency pipe.
- Returns R with the originating requester id.
- Provides a drain handshake so software/control can quiesce the unit before power or mode changes.

Parameters:
- NREQ, 4, number of requesters (2..8)
- LAT, 2, posedges from FPU input applied to R valid; must match the FPU build
- IDW, $clog2(NREQ), requester id width (derived, not overridable)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot grant; handshake when valid&ready at posedge
- req_fmt  in  NREQ x fp_fmt_e  per-requester format
- req_op  in  NREQ x fp_op_e  per-requester opcode
- req_x  in  NREQ x 32  operand X
- req_y  in  NREQ x 32  operand Y
- fpu_fmt  out  fp_fmt_e  registered to FPU fmt
- fpu_op  out  fp_op_e  registered to FPU opcode
- fpu_x  out  32  registered to FPU X
- fpu_y  out  32  registered to FPU Y
- fpu_r  in  32  FPU result R
- rsp_valid  out  1  response valid, single cycle, no backpressure
- rsp_id  out  IDW  requester index of response
- rsp_data  out  32  equals fpu_r when rsp_valid
- drain_req  in  1  level: stop accepting, flush pipe
- drained  out  1  high while DRAINED and pipe empty

Behaviour:
- Reset (async, rst_n=0):
  - req_ready=0, rsp_valid=0, rsp_id=0, drained=0.
  - fpu_x=fpu_y=0, fpu_fmt=FP32, fpu_op=OP_ADD.
  - RR pointer=0, tag pipe cleared, state=RUN.
- Arbitration:
  - Combinational round-robin over req_valid starting at pointer.
  - req_ready is one-hot on the winner, all zero if none valid or state!=RUN.
  - req_ready may depend on req_valid; a requester must hold its request until accepted.
- Issue on accept at posedge k:
  - fpu_* load the winner's fields.
  - Pointer becomes winner+1 mod NREQ.
  - Tag {1,id} enters the tag pipe.
- Idle cycles: fpu_* hold their last values, and an invalid tag enters the pipe.
- Throughput and latency:
  - One issue per cycle, fully pipelined.
  - rsp_valid/rsp_id are asserted for the cycle following posedge k+LAT, aligned with fpu_r.
  - rsp_data is combinational from fpu_r, masked to 0 when !rsp_valid.
- FSM:
  - RUN -> DRAINING when drain_req=1 (sampled at posedge; no accept in that cycle or after).
  - DRAINING -> DRAINED when the tag pipe is empty.
  - DRAINED -> RUN when drain_req=0.
  - DRAINING -> RUN if drain_req drops before empty.
  - drained=1 only in DRAINED.
- Simultaneous drain_req rise and request: the request is not accepted.
- A reset mid-flight discards all in-flight tags; no response is emitted for them.
- Pointer wrap: NREQ-1 -> 0. The pointer advances only on accept.

Optional Feature:
- Macro FPSCHED_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_issue_cnt[31:0]: count of accepts.
  - perf_stall_cnt[31:0]: cycles with |req_valid & no accept.
- Both counters reset to 0 and saturate at 32'hFFFFFFFF.
- When undefined, the ports and logic are absent, and the remaining behaviour is identical.

Decomposition:
- FPALL_pkg: fp_fmt_e and fp_op_e (reused), plus new sched_state_e {RUN, DRAINING, DRAINED} and a packed fpreq_t {fmt, op, x, y}.
- One sub-module, fpall_rr_arb: parameterized NREQ, inputs req, ptr; outputs one-hot gnt and gnt_idx, combinational.
- Tag pipe and FSM live in fpall_req_sched.

Test Plan:
- Single requester 2, X=3F800000 Y=40000000 FP32 OP_ADD:
  - accepted at edge k;
  - rsp_valid after edge k+2 with rsp_id=2, rsp_data=40400000.
- All 4 valid continuously, pointer 0:
  - grants in order 0,1,2,3,0;
  - responses return in the same order, one per cycle, each id paired with its own sum (ref: shortreal add).
- Back-to-back from requester 1 plus sporadic requester 3:
  - no starvation; requester 3 is granted within NREQ cycles of asserting.
- drain_req raised with 2 ops in flight:
  - req_ready=0 immediately;
  - both responses emitted;
  - drained=1 the cycle after the last rsp_valid;
  - drop drain_req -> grants resume next cycle.
- rst_n pulsed low with 2 ops in flight:
  - no rsp_valid afterwards;
  - outputs at reset values;
  - pointer restarts at 0.
- With FPSCHED_PERF_CNT_EN, 10 accepts plus 3 stall cycles:
  - perf_issue_cnt=10, perf_stall_cnt=3.
